mul_seq_radix4: RTL

//  Iterative radix-4 shift-add multiplier. Each cycle it retires 2 bits of B

---
 rtl/mul_seq_radix4_pkg.sv | 17 +
 rtl/mul_seq_radix4_if.sv | 30 +++
 rtl/mul_seq_radix4_pp_step.sv | 31 +++
 rtl/mul_seq_radix4.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mul_seq_radix4_pkg.sv
// Shared types and helpers for the sequential radix-4 multiplier.
//   mul_state_e : FSM state encoding (IDLE / CALC / DONE)
//   cnt_width() : step-counter width, clog2 of the step count with a minimum of 1
package mul_seq_radix4_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Counter width able to index 0..steps-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/mul_seq_radix4_if.sv
// Operand/result handshake bundle for mul_seq_radix4.
//   in_valid/in_ready   : operand handshake carrying a, b, is_signed
//   out_valid/out_ready : result handshake carrying p (2*WIDTH bits)
//   busy                : multiplier is in CALC or DONE
// master = producer/consumer side, slave = multiplier side.
interface mul_seq_radix4_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   is_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     p;
  logic                   busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/mul_seq_radix4_pp_step.sv
// One radix-4 accumulate step: acc_o = acc_i + a_mag_i * b2_i.
//   a_mag_i : WIDTH-bit unsigned multiplicand magnitude
//   b2_i    : two multiplier bits retired this step (selects 0/A/2A/3A)
//   acc_i   : WIDTH-bit upper accumulator window
//   acc_o   : WIDTH+2-bit sum (cannot overflow: < 2^W + 3*(2^W-1))
module mul_pp_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_mag_i,
  input  logic [1:0]       b2_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH+1:0] acc_o
);

  localparam int unsigned SW = WIDTH + 2;

  logic [SW-1:0] pp_c;

  // Partial-product select; 3A is built from A + 2A.
  always_comb begin
    pp_c = '0;
    case (b2_i)
      2'd0:    pp_c = '0;
      2'd1:    pp_c = SW'(a_mag_i);
      2'd2:    pp_c = SW'({a_mag_i, 1'b0});
      default: pp_c = SW'(a_mag_i) + SW'({a_mag_i, 1'b0});
    endcase
    acc_o = pp_c + SW'(acc_i);
  end

endmodule

// File: rtl/mul_seq_radix4.sv
// Iterative radix-4 shift-add multiplier, WIDTH/2 steps per product.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of mul_seq_radix4_if (operands in, product out)
// Signed mode multiplies magnitudes and negates the product as it is written
// to p on the CALC->DONE edge. Low product bits are retired two per step into
// lo_q; the upper window hi_q is re-added each step and shifted right by two.
module mul_seq_radix4
  import mul_seq_radix4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mul_seq_radix4_if.slave   bus
);

  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned LW    = WIDTH - 2;

  mul_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_mag_q;
  logic [WIDTH-1:0]  b_q;
  logic              neg_q;
  logic [WIDTH-1:0]  hi_q;
  logic [LW-1:0]     lo_q;
  logic [PW-1:0]     p_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [WIDTH-1:0]  a_abs_c;
  logic [WIDTH-1:0]  b_abs_c;
  logic [WIDTH+1:0]  sum_c;
  logic [PW-1:0]     full_c;
  logic [PW-1:0]     p_next_c;
  logic              last_c;

  // Operand magnitudes; the most-negative value maps to 2^(W-1) unchanged.
  always_comb begin
    a_abs_c = bus.a;
    b_abs_c = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) a_abs_c = -bus.a;
    if (bus.is_signed && bus.b[WIDTH-1]) b_abs_c = -bus.b;
  end

  mul_pp_step #(.WIDTH(WIDTH)) u_pp_step (
    .a_mag_i (a_mag_q),
    .b2_i    (b_q[1:0]),
    .acc_i   (hi_q),
    .acc_o   (sum_c)
  );

  // On the final step sum_c is the top W+2 bits and lo_q the bottom W-2.
  always_comb begin
    last_c   = (cnt_q == CW'(STEPS - 1));
    full_c   = {sum_c, lo_q};
    p_next_c = neg_q ? -full_c : full_c;
  end

  // FSM with registered outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      cnt_q       <= '0;
      a_mag_q     <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_mag_q    <= a_abs_c;
            b_q        <= b_abs_c;
            neg_q      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= MUL_CALC;
          end
        end
        MUL_CALC: begin
          hi_q  <= sum_c[WIDTH+1:2];
          b_q   <= b_q >> 2;
          cnt_q <= cnt_q + CW'(1);
          if (last_c) begin
            p_q         <= p_next_c;
            out_valid_q <= 1'b1;
            state_q     <= MUL_DONE;
          end else begin
            // Two product bits become final each non-final step.
            lo_q[{cnt_q, 1'b0} +: 2] <= sum_c[1:0];
          end
        end
        MUL_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= MUL_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= MUL_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign bus.busy      = busy_q;

endmodule
